// File: rtl/gshare_branch_tracker.sv
// In-order branch tracking queue between fetch and a gshare predictor.
// Records each lookup's {pc, history, pred} and emits one registered training update per resolve.
module gshare_branch_tracker #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 7,
  parameter int HIST_W = 7
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       fe_valid,
  input  logic [PC_W-1:0]            fe_pc,
  output logic                       fe_ready,
  output logic                       fe_taken,
  output logic                       predict_valid,
  output logic [PC_W-1:0]            predict_pc,
  input  logic                       predict_taken,
  input  logic [HIST_W-1:0]          predict_history,
  input  logic                       ex_valid,
  input  logic                       ex_taken,
  output logic                       train_valid,
  output logic                       train_taken,
  output logic                       train_mispredicted,
  output logic [PC_W-1:0]            train_pc,
  output logic [HIST_W-1:0]          train_history,
  output logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [HIST_W-1:0] hist_q [DEPTH];
  logic              pred_q [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          tv_q, tt_q, tm_q, flush_q;
  logic [PC_W-1:0]   tpc_q;
  logic [HIST_W-1:0] thist_q;
  logic          push, pop, mispred;

  // Lookups are blocked while the predictor rolls back its history.
  assign fe_ready      = !areset && (count_q < FULL) && !flush_q;
  assign predict_valid = fe_valid && fe_ready;
  assign predict_pc    = fe_pc;
  assign fe_taken      = predict_taken;

  assign push    = predict_valid;
  assign pop     = ex_valid && (count_q != '0);
  assign mispred = ex_taken != pred_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | (ex_valid & (count_q == '0));
    if (pop && mispred) begin
      // Everything younger than the mispredicted branch is wrong-path, including this cycle's lookup.
      head_d  = head_q + 1'b1;
      tail_d  = head_q + 1'b1;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      tv_q    <= 1'b0;
      tt_q    <= 1'b0;
      tm_q    <= 1'b0;
      tpc_q   <= '0;
      thist_q <= '0;
      flush_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      tv_q    <= pop;
      flush_q <= pop && mispred;
      if (pop) begin
        tt_q    <= ex_taken;
        tm_q    <= mispred;
        tpc_q   <= pc_q[head_q];
        thist_q <= hist_q[head_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]   <= fe_pc;
      hist_q[tail_q] <= predict_history;
      pred_q[tail_q] <= predict_taken;
    end
  end

  assign train_valid        = tv_q;
  assign train_taken        = tt_q;
  assign train_mispredicted = tm_q;
  assign train_pc           = tpc_q;
  assign train_history      = thist_q;
  assign flush              = flush_q;
  assign count              = count_q;
  assign err                = err_q;
endmodule

// File: tb/tb_gshare_branch_tracker.sv
// Bench for gshare_branch_tracker: directed scenarios plus random traffic against a queue model.
module tb_gshare_branch_tracker;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 7;
  localparam int HIST_W = 7;
  localparam int CW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic areset;
  logic fe_valid, fe_ready, fe_taken, predict_valid, predict_taken;
  logic [PC_W-1:0] fe_pc, predict_pc, train_pc;
  logic [HIST_W-1:0] predict_history, train_history;
  logic ex_valid, ex_taken;
  logic train_valid, train_taken, train_mispredicted, flush, err;
  logic [CW-1:0] count;

  gshare_branch_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W)) dut (
    .clk(clk), .areset(areset),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_ready(fe_ready), .fe_taken(fe_taken),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .predict_taken(predict_taken), .predict_history(predict_history),
    .ex_valid(ex_valid), .ex_taken(ex_taken),
    .train_valid(train_valid), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_pc(train_pc),
    .train_history(train_history), .flush(flush), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [HIST_W-1:0] hist;
    logic              pred;
  } ent_t;

  ent_t mq[$];
  bit m_err, m_flush, m_tv, m_tt, m_tm, m_rst;
  logic [PC_W-1:0]   m_tpc;
  logic [HIST_W-1:0] m_thist;
  int n_checks, n_fail, n_train;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already applied; check the lookup path, advance the model, then check registered outputs.
  task automatic cycle();
    bit rdy, pv, mis;
    ent_t h, e;
    rdy = !areset && (mq.size() < DEPTH) && !m_flush;
    pv  = fe_valid && rdy;
    #1;
    chk("fe_ready", fe_ready, rdy);
    chk("predict_valid", predict_valid, pv);
    chk("fe_taken", fe_taken, predict_taken);
    if (pv) chk("predict_pc", predict_pc, fe_pc);
    if (m_flush) chk("no_lookup_in_flush", predict_valid, 0);

    m_tv = 0; mis = 0;
    if (areset) begin
      mq.delete();
      m_err = 0; m_flush = 0; m_tt = 0; m_tm = 0; m_tpc = '0; m_thist = '0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (ex_valid) begin
        if (mq.size() == 0) m_err = 1;
        else begin
          h = mq.pop_front();
          m_tv = 1; m_tt = ex_taken; m_tm = (ex_taken != h.pred);
          m_tpc = h.pc; m_thist = h.hist; mis = m_tm;
          n_train++;
          if (mis) mq.delete();
        end
      end
      if (pv && !mis) begin
        e.pc = fe_pc; e.hist = predict_history; e.pred = predict_taken;
        mq.push_back(e);
      end
      m_flush = m_tv && mis;
    end

    @(posedge clk); #1;
    chk("count", count, mq.size());
    chk("err", err, m_err);
    chk("train_valid", train_valid, m_tv);
    chk("flush", flush, m_flush);
    if (count > DEPTH) chk("count_bound", count, DEPTH);
    if (m_tv || m_rst) begin
      chk("train_pc", train_pc, m_tpc);
      chk("train_history", train_history, m_thist);
      chk("train_taken", train_taken, m_tt);
      chk("train_mispredicted", train_mispredicted, m_tm);
    end
  endtask

  task automatic idle();
    fe_valid = 0; ex_valid = 0;
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hs, input logic tk);
    fe_valid = 1; fe_pc = pc; predict_history = hs; predict_taken = tk;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_train = 0;
    m_err = 0; m_flush = 0; m_tv = 0; m_tt = 0; m_tm = 0; m_rst = 0;
    m_tpc = '0; m_thist = '0;
    areset = 1; fe_valid = 0; fe_pc = '0; predict_taken = 0; predict_history = '0;
    ex_valid = 0; ex_taken = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_count", count, 0);
    chk("rst_train_valid", train_valid, 0);
    chk("rst_train_pc", train_pc, 0);
    areset = 0;

    // Single mispredicted branch.
    lookup(7'd3, 7'd0, 1'b0); cycle();
    chk("s1_count", count, 1);
    idle(); ex_valid = 1; ex_taken = 1; cycle();
    chk("s1_train_pc", train_pc, 3);
    chk("s1_mispred", train_mispredicted, 1);
    chk("s1_flush", flush, 1);
    chk("s1_fe_ready", fe_ready, 0);
    idle(); cycle();
    chk("s1_count_after", count, 0);

    // Fill to capacity, then a correct resolve frees a slot.
    for (int i = 0; i < DEPTH + 1; i++) begin
      lookup(7'(10 + i), 7'(i), 1'b1); cycle();
    end
    chk("s2_full", count, DEPTH);
    chk("s2_ready_full", fe_ready, 0);
    idle(); ex_valid = 1; ex_taken = 1; cycle();
    chk("s2_mispred", train_mispredicted, 0);
    chk("s2_count", count, DEPTH - 1);
    chk("s2_ready", fe_ready, 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      idle(); ex_valid = 1; ex_taken = 1; cycle();
    end

    // Mispredict with a same-cycle lookup drops both younger branches.
    n_train = 0;
    idle();
    lookup(7'd5, 7'd1, 1'b0); cycle();
    lookup(7'd6, 7'd2, 1'b0); cycle();
    lookup(7'd7, 7'd3, 1'b0); cycle();
    idle(); ex_valid = 1; ex_taken = 0; cycle();
    chk("s3_pc5", train_pc, 5);
    lookup(7'd8, 7'd4, 1'b0); ex_valid = 1; ex_taken = 1; cycle();
    chk("s3_pc6", train_pc, 6);
    chk("s3_count", count, 0);
    idle(); cycle(); cycle();
    chk("s3_pulses", n_train, 2);

    // Simultaneous enqueue and correct resolve at count 2.
    lookup(7'd20, 7'h2a, 1'b1); cycle();
    lookup(7'd21, 7'h15, 1'b0); cycle();
    lookup(7'd22, 7'h33, 1'b1); ex_valid = 1; ex_taken = 1; cycle();
    chk("s4_count", count, 2);
    chk("s4_hist", train_history, 7'h2a);
    idle(); ex_valid = 1; ex_taken = 0; cycle();
    idle(); ex_valid = 1; ex_taken = 1; cycle();
    idle(); cycle();

    // Resolve on an empty queue.
    idle(); ex_valid = 1; ex_taken = 1; cycle();
    chk("s5_no_train", train_valid, 0);
    chk("s5_err", err, 1);

    // Random traffic; occasional mid-run reset.
    for (int c = 0; c < 500; c++) begin
      areset          = ($urandom_range(0, 63) == 0);
      fe_valid        = ($urandom_range(0, 3) != 0);
      fe_pc           = 7'($urandom);
      predict_taken   = 1'($urandom);
      predict_history = 7'($urandom);
      ex_valid        = ($urandom_range(0, 2) == 0);
      ex_taken        = 1'($urandom);
      cycle();
    end
    areset = 0; idle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
